// File: rtl/cnt_seq_pkg.sv
// Shared constants for the period-counter sequencer: FSM state encoding and
// timeout counter sizing.
package cnt_seq_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  localparam int unsigned TIMEOUT_DEFAULT = 300;

  // Wide enough to hold the value G_TIMEOUT itself.
  function automatic int unsigned to_cnt_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int unsigned TO_CNT_W = to_cnt_width(TIMEOUT_DEFAULT);

endpackage

// File: rtl/cnt_seq_timeout.sv
// Inter-pulse watchdog: counts idle RUN cycles and flags when the limit is reached.
module cnt_seq_timeout
  import cnt_seq_pkg::*;
#(
  parameter int unsigned G_TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_incr,
  output logic o_expired
);

  localparam int unsigned CntW = to_cnt_width(G_TIMEOUT);
  localparam logic [CntW-1:0] Limit = CntW'(G_TIMEOUT);

  logic [CntW-1:0] count_q, count_d;

  // Saturate at the limit so a stalled count can never wrap back below it.
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_incr && (count_q != Limit)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_expired = (count_q == Limit);

endmodule

// File: rtl/cnt_sequencer.sv
// Runs a peer period counter for a requested number of periods, with abort and
// an inter-pulse timeout; all outputs are registered.
module cnt_sequencer
  import cnt_seq_pkg::*;
#(
  parameter int unsigned G_NB_WIDTH = 8,
  parameter int unsigned G_TIMEOUT  = 300
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [G_NB_WIDTH-1:0] i_nb_period,
  input  logic                  i_abort,
  input  logic                  i_cnt_done,
  output logic                  o_en_cnt,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_aborted,
  output logic                  o_err,
  output logic [G_NB_WIDTH-1:0] o_period_cnt
);

  state_t                  state_q, state_d;
  logic [G_NB_WIDTH-1:0]   nb_q, nb_d;
  logic [G_NB_WIDTH-1:0]   cnt_q, cnt_d;
  logic [G_NB_WIDTH-1:0]   cnt_inc;
  logic                    run_q;
  logic                    done_q, done_d;
  logic                    aborted_q, aborted_d;
  logic                    err_q, err_d;
  logic                    to_clear, to_incr, to_expired;

  cnt_seq_timeout #(
    .G_TIMEOUT (G_TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (to_clear),
    .i_incr    (to_incr),
    .o_expired (to_expired)
  );

  assign cnt_inc = cnt_q + 1'b1;

  // Priority in RUN: completion, then abort, then timeout.
  always_comb begin
    state_d   = state_q;
    nb_d      = nb_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    err_d     = 1'b0;
    to_clear  = 1'b0;
    to_incr   = 1'b0;
    if (state_q == ST_IDLE) begin
      if (i_start) begin
        nb_d     = i_nb_period;
        cnt_d    = '0;
        to_clear = 1'b1;
        if (i_nb_period == '0) begin
          done_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
    end else begin
      if (i_cnt_done) begin
        cnt_d    = cnt_inc;
        to_clear = 1'b1;
      end else begin
        to_incr = 1'b1;
      end
      if (i_cnt_done && (cnt_inc == nb_q)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else if (i_abort) begin
        state_d   = ST_IDLE;
        aborted_d = 1'b1;
      end else if (!i_cnt_done && to_expired) begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      nb_q      <= '0;
      cnt_q     <= '0;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      nb_q      <= nb_d;
      cnt_q     <= cnt_d;
      run_q     <= (state_d == ST_RUN);
      done_q    <= done_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
    end
  end

  assign o_en_cnt     = run_q;
  assign o_busy       = run_q;
  assign o_done       = done_q;
  assign o_aborted    = aborted_q;
  assign o_err        = err_q;
  assign o_period_cnt = cnt_q;

endmodule

// File: tb/tb_cnt_sequencer.sv
// Directed bench for cnt_sequencer: one task per scenario, inline checks.
module tb_cnt_sequencer;

  localparam int unsigned NbW     = 8;
  localparam int unsigned Timeout = 300;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_start;
  logic [NbW-1:0] i_nb_period;
  logic           i_abort;
  logic           i_cnt_done;
  logic           o_en_cnt;
  logic           o_busy;
  logic           o_done;
  logic           o_aborted;
  logic           o_err;
  logic [NbW-1:0] o_period_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cnt_sequencer #(
    .G_NB_WIDTH (NbW),
    .G_TIMEOUT  (Timeout)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_nb_period  (i_nb_period),
    .i_abort      (i_abort),
    .i_cnt_done   (i_cnt_done),
    .o_en_cnt     (o_en_cnt),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_aborted    (o_aborted),
    .o_err        (o_err),
    .o_period_cnt (o_period_cnt)
  );

  // Advance one clock; inputs change and outputs are observed 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input logic [NbW-1:0] nb);
    i_start     = 1'b1;
    i_nb_period = nb;
    step();
    i_start = 1'b0;
  endtask

  task automatic pulse_done();
    i_cnt_done = 1'b1;
    step();
    i_cnt_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if ({o_en_cnt, o_busy, o_done, o_aborted, o_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000",
               {o_en_cnt, o_busy, o_done, o_aborted, o_err});
    end
    checks++;
    if (o_period_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d expected 0", o_period_cnt);
    end
  endtask

  task automatic test_nb3();
    int en_cycles;
    int done_cnt;
    int done_cyc;
    logic busy_at_done;
    en_cycles    = 0;
    done_cnt     = 0;
    done_cyc     = -1;
    busy_at_done = 1'b1;
    start_seq(8'd3);
    checks++;
    if (o_en_cnt !== 1'b1 || o_busy !== 1'b1 || o_period_cnt !== 8'd0) begin
      errors++;
      $display("FAIL nb3_start: en=%b busy=%b cnt=%0d expected 1 1 0",
               o_en_cnt, o_busy, o_period_cnt);
    end
    if (o_en_cnt === 1'b1) en_cycles++;
    for (int cyc = 1; cyc <= 800; cyc++) begin
      i_cnt_done = ((cyc % 257) == 0) && (cyc <= 771);
      step();
      if (i_cnt_done) begin
        checks++;
        if (o_period_cnt !== NbW'(cyc / 257)) begin
          errors++;
          $display("FAIL nb3_step%0d: cnt=%0d expected %0d", cyc / 257, o_period_cnt, cyc / 257);
        end
      end
      if (o_en_cnt === 1'b1) en_cycles++;
      if (o_done === 1'b1) begin
        done_cnt++;
        done_cyc     = cyc;
        busy_at_done = o_busy;
      end
    end
    i_cnt_done = 1'b0;
    checks++;
    if (en_cycles != 771) begin
      errors++;
      $display("FAIL nb3_en_cycles: got %0d expected 771", en_cycles);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 771) begin
      errors++;
      $display("FAIL nb3_done: count=%0d at=%0d expected 1 at 771", done_cnt, done_cyc);
    end
    checks++;
    if (busy_at_done !== 1'b0) begin
      errors++;
      $display("FAIL nb3_busy_fall: busy=%b with done, expected 0", busy_at_done);
    end
  endtask

  task automatic test_nb0();
    int en_seen;
    en_seen = 0;
    start_seq(8'd0);
    if (o_en_cnt === 1'b1) en_seen++;
    checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_period_cnt !== 8'd0) begin
      errors++;
      $display("FAIL nb0_done: done=%b busy=%b cnt=%0d expected 1 0 0",
               o_done, o_busy, o_period_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      if (o_en_cnt === 1'b1) en_seen++;
    end
    checks++;
    if (en_seen != 0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL nb0_quiet: en cycles=%0d done=%b expected 0 0", en_seen, o_done);
    end
  endtask

  task automatic test_abort();
    start_seq(8'd5);
    for (int p = 0; p < 2; p++) begin
      step();
      step();
      step();
      pulse_done();
    end
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    checks++;
    if (o_aborted !== 1'b1 || o_done !== 1'b0 || o_en_cnt !== 1'b0 || o_period_cnt !== 8'd2) begin
      errors++;
      $display("FAIL abort: aborted=%b done=%b en=%b cnt=%0d expected 1 0 0 2",
               o_aborted, o_done, o_en_cnt, o_period_cnt);
    end
    step();
    checks++;
    if (o_aborted !== 1'b0 || o_done !== 1'b0 || o_period_cnt !== 8'd2) begin
      errors++;
      $display("FAIL abort_after: aborted=%b done=%b cnt=%0d expected 0 0 2",
               o_aborted, o_done, o_period_cnt);
    end
  endtask

  task automatic test_abort_vs_done();
    start_seq(8'd2);
    step();
    pulse_done();
    step();
    i_abort    = 1'b1;
    i_cnt_done = 1'b1;
    step();
    i_abort    = 1'b0;
    i_cnt_done = 1'b0;
    checks++;
    if (o_done !== 1'b1 || o_aborted !== 1'b0 || o_period_cnt !== 8'd2 || o_en_cnt !== 1'b0) begin
      errors++;
      $display("FAIL abort_vs_done: done=%b aborted=%b cnt=%0d en=%b expected 1 0 2 0",
               o_done, o_aborted, o_period_cnt, o_en_cnt);
    end
  endtask

  task automatic test_back_to_back();
    start_seq(8'd1);
    checks++;
    if (o_en_cnt !== 1'b1 || o_period_cnt !== 8'd0) begin
      errors++;
      $display("FAIL b2b_start: en=%b cnt=%0d expected 1 0", o_en_cnt, o_period_cnt);
    end
    pulse_done();
    checks++;
    if (o_done !== 1'b1 || o_period_cnt !== 8'd1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: done=%b cnt=%0d busy=%b expected 1 1 0",
               o_done, o_period_cnt, o_busy);
    end
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    start_seq(8'd4);
    step();
    pulse_done();
    for (int k = 1; k <= 300; k++) begin
      step();
      if (o_err !== 1'b0 || o_en_cnt !== 1'b1) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL timeout_early: %0d bad cycles before 301, expected 0", early);
    end
    step();
    checks++;
    if (o_err !== 1'b1 || o_en_cnt !== 1'b0 || o_period_cnt !== 8'd1 || o_aborted !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err: err=%b en=%b cnt=%0d aborted=%b expected 1 0 1 0",
               o_err, o_en_cnt, o_period_cnt, o_aborted);
    end
    step();
    checks++;
    if (o_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: err=%b expected 0", o_err);
    end
  endtask

  task automatic test_start_in_run();
    int done_at;
    done_at = 0;
    start_seq(8'd3);
    pulse_done();
    start_seq(8'd7);
    checks++;
    if (o_busy !== 1'b1 || o_period_cnt !== 8'd1) begin
      errors++;
      $display("FAIL ign_start: busy=%b cnt=%0d expected 1 1", o_busy, o_period_cnt);
    end
    for (int p = 2; p <= 3; p++) begin
      step();
      pulse_done();
      if (o_done === 1'b1) done_at = p;
    end
    checks++;
    if (done_at != 3 || o_period_cnt !== 8'd3) begin
      errors++;
      $display("FAIL ign_start_nb: done after pulse %0d cnt=%0d expected 3 3",
               done_at, o_period_cnt);
    end
  endtask

  task automatic test_rst_mid();
    int pulses;
    pulses = 0;
    start_seq(8'd3);
    pulse_done();
    rst = 1'b1;
    i_cnt_done = 1'b1;
    step();
    rst = 1'b0;
    i_cnt_done = 1'b0;
    checks++;
    if ({o_en_cnt, o_busy, o_done, o_aborted, o_err} !== 5'b0 || o_period_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid: flags=%b cnt=%0d expected 00000 0",
               {o_en_cnt, o_busy, o_done, o_aborted, o_err}, o_period_cnt);
    end
    i_abort = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (o_done === 1'b1 || o_aborted === 1'b1 || o_err === 1'b1 || o_en_cnt === 1'b1) pulses++;
    end
    i_abort = 1'b0;
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL rst_quiet: %0d active cycles after reset, expected 0", pulses);
    end
  endtask

  initial begin
    rst         = 1'b1;
    i_start     = 1'b0;
    i_nb_period = '0;
    i_abort     = 1'b0;
    i_cnt_done  = 1'b0;
    test_reset();
    test_nb3();
    test_nb0();
    test_abort();
    test_abort_vs_done();
    test_back_to_back();
    test_timeout();
    test_start_in_run();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnt_sequencer.md
CNT_SEQUENCER -- requirements
Module: cnt_sequencer

Interface
REQ-001 G_NB_WIDTH, 8: width of the requested period count and the completed-period count.
REQ-002 G_TIMEOUT, 300: maximum number of cycles allowed between o_en_cnt assertion or the last i_cnt_done and the next i_cnt_done; must be at least 2.
REQ-003 clk  in  1  single clock for all state; all ports are sampled and driven on the rising edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 i_start  in  1  one-cycle request to begin a sequence.
REQ-006 i_nb_period  in  G_NB_WIDTH  number of counter periods to run; sampled only when a start is accepted.
REQ-007 i_abort  in  1  cancels a running sequence.
REQ-008 i_cnt_done  in  1  one-cycle period-complete pulse from the peer period counter.
REQ-009 o_en_cnt  out  1  enable to the peer period counter; held high for the whole sequence.
REQ-010 o_busy  out  1  high while a sequence runs.
REQ-011 o_done  out  1  one-cycle pulse on normal completion.
REQ-012 o_aborted  out  1  one-cycle pulse on abort.
REQ-013 o_err  out  1  one-cycle pulse on timeout.
REQ-014 o_period_cnt  out  G_NB_WIDTH  number of periods completed in the current or most recent sequence.

Function
REQ-015 The block SHALL implement the states IDLE and RUN, with every output registered.
REQ-016 In IDLE, when i_start=1, the block SHALL latch i_nb_period, clear o_period_cnt, and enter RUN in the next cycle with o_en_cnt=1 and o_busy=1.
REQ-017 If i_start=1 with i_nb_period=0, the block SHALL remain in IDLE, pulse o_done in the next cycle, and never assert o_en_cnt.
REQ-018 In RUN, o_en_cnt SHALL stay high continuously, with no gaps between periods.
REQ-019 In RUN, each i_cnt_done pulse SHALL increment o_period_cnt by 1 in the next cycle.
REQ-020 In RUN, an i_cnt_done that makes o_period_cnt equal the latched count SHALL, in the next cycle, return the block to IDLE with o_en_cnt=0, o_busy=0 and a one-cycle o_done pulse.
REQ-021 In RUN, i_abort=1 SHALL, in the next cycle, return the block to IDLE with o_en_cnt=0 and a one-cycle o_aborted pulse, and SHALL NOT pulse o_done.
REQ-022 If i_abort and the final i_cnt_done arrive in the same cycle, completion SHALL win: o_done pulses and o_aborted does not.
REQ-023 A non-final i_cnt_done coinciding with i_abort SHALL still increment o_period_cnt, and the abort SHALL then take effect.
REQ-024 The timeout counter SHALL clear on entry to RUN and on each i_cnt_done, and increment on every other RUN cycle.
REQ-025 When the timeout counter reaches G_TIMEOUT, the block SHALL, in the next cycle, return to IDLE with o_en_cnt=0 and a one-cycle o_err pulse.
REQ-026 Priority of simultaneous RUN events SHALL be: completion, then abort, then timeout.
REQ-027 i_start SHALL be ignored while in RUN; i_abort and i_cnt_done SHALL be ignored while in IDLE.
REQ-028 o_period_cnt SHALL hold its value in IDLE until the next accepted start.
REQ-029 o_period_cnt SHALL never wrap, since it stops at the latched count of at most 2^G_NB_WIDTH-1.
REQ-030 After o_done, o_aborted or o_err, a new i_start SHALL be accepted in the following cycle, giving back-to-back sequences with one IDLE cycle between them.

Reset
REQ-031 On rst=1, the block SHALL enter IDLE and drive o_en_cnt, o_busy, o_done, o_aborted, o_err and o_period_cnt to 0, and clear the timeout counter and the latched count.
REQ-032 Reset asserted during RUN SHALL take priority over all events, deassert o_en_cnt in the next cycle, and produce no o_done, o_aborted or o_err pulse.

Structure
REQ-033 Package cnt_seq_pkg SHALL hold the state enumeration and the timeout counter width constant, computed as clog2(G_TIMEOUT+1).
REQ-034 The timeout counter SHALL be a sub-module, cnt_seq_timeout, with clear, increment and expired ports.
REQ-035 The sequencing FSM and the period counter SHALL stay in cnt_sequencer.

Verification
REQ-036 The bench SHALL cover each of the following scenarios:
- Start with nb=3 and a peer model pulsing i_cnt_done every 257 cycles -> o_en_cnt high for 771 cycles, o_period_cnt steps 1,2,3, one o_done, o_busy falls with o_done.
- Start with nb=0 -> o_done one cycle later, o_en_cnt never high, o_period_cnt=0.
- nb=5 with i_abort after 2 pulses -> o_aborted, no o_done, o_period_cnt=2, o_en_cnt low next cycle.
- nb=2 with i_abort coincident with the 2nd i_cnt_done -> o_done only, o_period_cnt=2.
- nb=4 with the peer stalled after 1 pulse and G_TIMEOUT=300 -> o_err 301 cycles after that pulse, o_period_cnt=1.
- rst mid-sequence and i_start during RUN -> all outputs 0 after reset with no pulses; the second start is ignored and the original nb is kept.
